// File: rtl/dynamic_bpredictor.sv
// Dynamic branch predictor: 2-bit counter BHT indexed by PC, trained by EXU resolutions.
// Optional gshare indexing with a non-speculative global history: PQR5_BP_GSHARE_EN.
module dynamic_bpredictor #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         GHR_W     = 6,
  localparam int        IDXW      = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            i_stall,
  input  logic            i_is_op_jal,
  input  logic            i_is_op_branch,
  input  logic [XLEN-1:0] i_immJ,
  input  logic [XLEN-1:0] i_immB,
  input  logic            i_instr_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_upd_valid,
  input  logic [IDXW-1:0] i_upd_idx,
  input  logic            i_upd_taken,
  output logic [XLEN-1:0] o_branch_pc,
  output logic            o_branch_taken,
  output logic            o_flush,
  output logic [IDXW-1:0] o_bht_idx
);

  logic [1:0]      bht [BHT_DEPTH];
  logic [IDXW-1:0] idx;
  logic [1:0]      look_cnt;
  logic [1:0]      upd_cur;
  logic [1:0]      upd_cnt;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] target;
  logic            taken;

`ifdef PQR5_BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign idx = i_pc[IDXW+1:2] ^ IDXW'(ghr);

  // History advances only on resolved branches, so lookups never see wrong-path bits
  generate
    if (GHR_W == 1) begin : g_ghr1
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
          ghr <= '0;
        else if (i_upd_valid)
          ghr <= i_upd_taken;
      end
    end else begin : g_ghrn
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
          ghr <= '0;
        else if (i_upd_valid)
          ghr <= {ghr[GHR_W-2:0], i_upd_taken};
      end
    end
  endgenerate
`else
  localparam int unused_ghr_w = GHR_W;

  assign idx = i_pc[IDXW+1:2];
`endif

  assign look_cnt = bht[idx];
  assign upd_cur  = bht[i_upd_idx];

  always_comb begin
    upd_cnt = upd_cur;
    if (i_upd_taken && upd_cur != 2'b11)
      upd_cnt = upd_cur + 2'b01;
    else if (!i_upd_taken && upd_cur != 2'b00)
      upd_cnt = upd_cur - 2'b01;
  end

  always_comb begin
    offset = '0;
    unique case (1'b1)
      i_is_op_jal:    offset = i_immJ;
      i_is_op_branch: offset = i_immB;
      default:        offset = '0;
    endcase
  end

  assign target = i_pc + offset;
  assign taken  = i_instr_valid &
                  (i_is_op_jal | (i_is_op_branch & look_cnt[1]));

  // Lookup reads the pre-update value: the write lands at this edge
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= CNT_INIT;
    end else if (i_upd_valid) begin
      bht[i_upd_idx] <= upd_cnt;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      o_branch_pc    <= '0;
      o_branch_taken <= 1'b0;
      o_bht_idx      <= '0;
    end else if (!i_stall) begin
      o_branch_pc    <= target;
      o_branch_taken <= taken;
      o_bht_idx      <= idx;
    end
  end

  // Flush self-clears so it can never be high on two consecutive cycles
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      o_flush <= 1'b0;
    else if (o_flush)
      o_flush <= 1'b0;
    else if (!i_stall)
      o_flush <= taken;
  end

endmodule
